// File: rtl/pri_dec_pkg.sv
// Shared types and constants for the pri_decode38 registered 3-to-8 decoder.
// Holds the FSM state enum, the index/output widths and the default hold length.
package pri_dec_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam int IDX_W        = 3;
    localparam int OUT_W        = 8;
    localparam int HOLD_DEFAULT = 4;

    // Counter only ever holds HOLD-1 down to 0, so HOLD=1 still needs one bit.
    function automatic int cnt_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/dec38_onehot.sv
// Purely combinational 3-to-8 one-hot decoder used by pri_decode38.
module dec38_onehot
    import pri_dec_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
            assign onehot[gi] = (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/pri_decode38.sv
// Registered 3-to-8 one-hot decoder with a hold timer and valid/ready input.
// Define PRI_DECODE38_ACTIVE_LOW_EN to drive y inverted (common-anode LED banks).
module pri_decode38
    import pri_dec_pkg::*;
#(
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] y,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = cnt_width(HOLD);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic [OUT_W-1:0]   r_y;
    logic [OUT_W-1:0]   w_y_next;
    logic [IDX_W-1:0]   w_dec_idx;
    logic [OUT_W-1:0]   w_onehot;
    logic               w_accept;
    logic               w_cnt_zero;

    // One decoder serves both the accept edge (live idx) and the hold (captured idx).
    assign w_dec_idx = (r_state == S_IDLE) ? idx : r_idx;

    dec38_onehot u_onehot (
        .idx    (w_dec_idx),
        .onehot (w_onehot)
    );

    assign in_ready   = en && (r_state == S_IDLE);
    assign w_accept   = in_ready && in_valid;
    assign w_cnt_zero = (r_cnt == '0);
    assign busy       = (r_state == S_HOLD);
    assign done       = (r_state == S_HOLD) && w_cnt_zero;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_y_next     = r_y;
        case (r_state)
            S_IDLE: begin
                w_y_next = '0;
                if (w_accept) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = CNT_LOAD;
                    w_idx_next   = idx;
                    w_y_next     = w_onehot;
                end
            end
            S_HOLD: begin
                // An enable drop aborts without a done pulse.
                if (!en) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                    w_y_next     = '0;
                end else if (w_cnt_zero) begin
                    w_state_next = S_IDLE;
                    w_y_next     = '0;
                end else begin
                    w_cnt_next   = r_cnt - CNT_W'(1);
                    w_y_next     = w_onehot;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_y_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_y     <= w_y_next;
        end
    end

`ifdef PRI_DECODE38_ACTIVE_LOW_EN
    assign y = ~r_y;
`else
    assign y = r_y;
`endif

endmodule

// File: tb/tb_pri_decode38.sv
// Self-checking bench for pri_decode38: one HOLD=4 instance and one HOLD=1 instance,
// checked every cycle against a remaining-cycles reference model.
module tb_pri_decode38;

    localparam int HA = 4;
    localparam int HB = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       a_en = 1'b0, a_valid = 1'b0;
    logic [2:0] a_idx = 3'd0;
    logic       a_ready, a_busy, a_done;
    logic [7:0] a_y;

    logic       b_en = 1'b0, b_valid = 1'b0;
    logic [2:0] b_idx = 3'd0;
    logic       b_ready, b_busy, b_done;
    logic [7:0] b_y;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles of the current hold still to show, and the decoded index.
    int         rem  [2] = '{0, 0};
    logic [2:0] mq   [2] = '{3'd0, 3'd0};
    int         hold [2] = '{HA, HB};

    pri_decode38 #(.HOLD(HA)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (a_en),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .idx      (a_idx),
        .y        (a_y),
        .busy     (a_busy),
        .done     (a_done)
    );

    pri_decode38 #(.HOLD(HB)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (b_en),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .idx      (b_idx),
        .y        (b_y),
        .busy     (b_busy),
        .done     (b_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] py(input logic [7:0] v);
`ifdef PRI_DECODE38_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int k, input logic en, input logic v, input logic [2:0] i);
        if (rem[k] > 0) begin
            if (!en) rem[k] = 0;
            else     rem[k] = rem[k] - 1;
        end else if (en && v) begin
            rem[k] = hold[k];
            mq[k]  = i;
        end
    endtask

    task automatic check_dut(input int k, input logic [7:0] y, input logic rdy,
                             input logic bsy, input logic dn, input logic en);
        logic [7:0] yexp;
        logic [7:0] ylog;
        string      p;
        p    = (k == 0) ? "a" : "b";
        yexp = (rem[k] > 0) ? (8'd1 << mq[k]) : 8'd0;
        chk({p, "_y"},     32'(y),   32'(py(yexp)));
        chk({p, "_ready"}, 32'(rdy), 32'(en && rem[k] == 0));
        chk({p, "_busy"},  32'(bsy), 32'(rem[k] > 0));
        chk({p, "_done"},  32'(dn),  32'(rem[k] == 1));
        ylog = py(y);
        chk({p, "_onehot"}, 32'($countones(ylog) <= 1), 32'd1);
    endtask

    task automatic check_all();
        check_dut(0, a_y, a_ready, a_busy, a_done, a_en);
        check_dut(1, b_y, b_ready, b_busy, b_done, b_en);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(0, a_en, a_valid, a_idx);
        model_edge(1, b_en, b_valid, b_idx);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        a_en = 1'b1;
        #2;
        chk("rst_y",     32'(a_y),     32'(py(8'h00)));
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_done",  32'(a_done),  32'd0);
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_b_y",   32'(b_y),     32'(py(8'h00)));
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Basic decode idx=3 for HOLD cycles
        a_valid = 1'b1; a_idx = 3'd3;
        cycle();
        a_valid = 1'b0; a_idx = 3'd1;
        chk("basic_y1", 32'(a_y), 32'(py(8'h08)));
        chk("basic_done1", 32'(a_done), 32'd0);
        repeat (3) cycle();
        chk("basic_y4", 32'(a_y), 32'(py(8'h08)));
        chk("basic_done4", 32'(a_done), 32'd1);
        cycle();
        chk("basic_after", 32'(a_y), 32'(py(8'h00)));

        // Back-to-back: idx=0 then idx=7 with in_valid held
        a_valid = 1'b1; a_idx = 3'd0;
        cycle();
        chk("b2b_first", 32'(a_y), 32'(py(8'h01)));
        repeat (4) cycle();
        chk("b2b_gap", 32'(a_y), 32'(py(8'h00)));
        chk("b2b_gap_ready", 32'(a_ready), 32'd1);
        a_idx = 3'd7;
        cycle();
        chk("b2b_second", 32'(a_y), 32'(py(8'h80)));
        repeat (3) cycle();
        a_valid = 1'b0;
        cycle();

        // Abort by dropping en
        a_valid = 1'b1; a_idx = 3'd6;
        cycle();
        a_valid = 1'b0;
        cycle();
        a_en = 1'b0;
        cycle();
        chk("abort_y", 32'(a_y), 32'(py(8'h00)));
        chk("abort_done", 32'(a_done), 32'd0);
        cycle();
        chk("abort_ready", 32'(a_ready), 32'd0);
        a_en = 1'b1;
        #1 chk("abort_ready_back", 32'(a_ready), 32'd1);

        // Asynchronous reset mid-hold
        @(negedge clk);
        a_valid = 1'b1; a_idx = 3'd5;
        cycle();
        a_valid = 1'b0;
        cycle();
        chk("mid_y_before", 32'(a_y), 32'(py(8'h20)));
        #2 rst_n = 1'b0;
        #1;
        rem[0] = 0; rem[1] = 0;
        chk("mid_rst_y", 32'(a_y), 32'(py(8'h00)));
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rst_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        check_all();

        // Exhaustive HOLD=1 on the second instance
        a_en = 1'b0;
        b_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_valid = 1'b1; b_idx = 3'(i);
            cycle();
            chk("h1_y", 32'(b_y), 32'(py(8'd1 << i)));
            chk("h1_done", 32'(b_done), 32'd1);
            b_valid = 1'b0;
            cycle();
            chk("h1_zero", 32'(b_y), 32'(py(8'h00)));
        end

        // Randomised traffic on both instances
        for (int n = 0; n < 400; n++) begin
            a_en    = ($urandom_range(0, 9) != 0);
            a_valid = 1'($urandom);
            a_idx   = 3'($urandom);
            b_en    = ($urandom_range(0, 9) != 0);
            b_valid = 1'($urandom);
            b_idx   = 3'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
